// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master sequencer: drives chip select, SCK and the load/shift
// strobes of an external shift register for one SPI_LEN-bit transfer.
module spi_master_ctrl #(
    parameter int unsigned SPI_LEN = 8,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Start,
    input  logic Abort,
    output logic IsLoad,
    output logic SftEn,
    output logic SckWr,
    output logic SckRd,
    output logic Sck,
    output logic CsN,
    output logic Busy,
    output logic Done
);

    localparam int unsigned BIT_W = $clog2(SPI_LEN + 1);
    localparam int unsigned DIV_W = 8;
    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SPI_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HOLD,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               sck_q, sck_d;
    logic               csn_q, csn_d;
    logic               is_load_q, is_load_d;
    logic               sft_en_q, sft_en_d;
    logic               sck_wr_q, sck_wr_d;
    logic               sck_rd_q, sck_rd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next state and counters; outputs are decoded from the next state so
    // that each registered output lines up with the state it belongs to.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sck_d    = sck_q;
        sck_wr_d = 1'b0;
        sck_rd_d = 1'b0;
        sft_en_d = 1'b0;

        if (Abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            div_d   = '0;
            bit_d   = '0;
            sck_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    div_d = '0;
                    bit_d = '0;
                    sck_d = 1'b0;
                    if (Start && !Abort) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_CS_SETUP;
                end
                S_CS_SETUP: begin
                    if (div_q == DIV_TC) begin
                        div_d   = '0;
                        state_d = S_SHIFT;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (div_q == DIV_TC) begin
                        div_d = '0;
                        if (!sck_q) begin
                            sck_d    = 1'b1;
                            sck_rd_d = 1'b1;
                            sft_en_d = 1'b1;
                        end else begin
                            sck_d = 1'b0;
                            bit_d = bit_q + BIT_W'(1);
                            // The falling edge after the last sample ends the
                            // shift phase without a shift-out strobe.
                            if (bit_q < BIT_LAST) begin
                                sck_wr_d = 1'b1;
                                sft_en_d = 1'b1;
                            end else begin
                                state_d = S_CS_HOLD;
                            end
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                S_CS_HOLD: begin
                    if (div_q == DIV_TC) begin
                        div_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    bit_d   = '0;
                    sck_d   = 1'b0;
                end
            endcase
        end

        is_load_d = (state_d == S_LOAD);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        csn_d     = !(state_d inside {S_LOAD, S_CS_SETUP, S_SHIFT, S_CS_HOLD});
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            sck_q     <= 1'b0;
            csn_q     <= 1'b1;
            is_load_q <= 1'b0;
            sft_en_q  <= 1'b0;
            sck_wr_q  <= 1'b0;
            sck_rd_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sck_q     <= sck_d;
            csn_q     <= csn_d;
            is_load_q <= is_load_d;
            sft_en_q  <= sft_en_d;
            sck_wr_q  <= sck_wr_d;
            sck_rd_q  <= sck_rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign IsLoad = is_load_q;
    assign SftEn  = sft_en_q;
    assign SckWr  = sck_wr_q;
    assign SckRd  = sck_rd_q;
    assign Sck    = sck_q;
    assign CsN    = csn_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: directed and randomized transfers, with a
// monitor that scores every completed transfer against a queued expectation.
module tb_spi_master_ctrl;

    localparam int unsigned SPI_LEN  = 8;
    localparam int unsigned CLK_DIV  = 2;
    localparam int          XFER_LEN = 2 + 2 * int'(CLK_DIV) * (int'(SPI_LEN) + 1);
    localparam int          F_LEN    = 2 + 2 * 1 * (int'(SPI_LEN) + 1);

    logic Clk = 1'b0;
    logic Rst, Start, Abort, Start_f, Abort_f;
    logic IsLoad, SftEn, SckWr, SckRd, Sck, CsN, Busy, Done;
    logic IsLoad_f, SftEn_f, SckWr_f, SckRd_f, Sck_f, CsN_f, Busy_f, Done_f;

    always #5 Clk = ~Clk;

    spi_master_ctrl #(.SPI_LEN(SPI_LEN), .CLK_DIV(CLK_DIV)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort),
        .IsLoad(IsLoad), .SftEn(SftEn), .SckWr(SckWr), .SckRd(SckRd),
        .Sck(Sck), .CsN(CsN), .Busy(Busy), .Done(Done)
    );

    spi_master_ctrl #(.SPI_LEN(SPI_LEN), .CLK_DIV(1)) dut_f (
        .Clk(Clk), .Rst(Rst), .Start(Start_f), .Abort(Abort_f),
        .IsLoad(IsLoad_f), .SftEn(SftEn_f), .SckWr(SckWr_f), .SckRd(SckRd_f),
        .Sck(Sck_f), .CsN(CsN_f), .Busy(Busy_f), .Done(Done_f)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [SPI_LEN-1:0] tx_q[$];
    logic [SPI_LEN-1:0] exp_q[$];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic int outs();
        return int'({CsN, Sck, Busy, IsLoad, SftEn, SckWr, SckRd, Done});
    endfunction

    function automatic int outs_f();
        return int'({CsN_f, Sck_f, Busy_f, IsLoad_f, SftEn_f, SckWr_f, SckRd_f, Done_f});
    endfunction

    // Monitor: follows one transfer at a time, models a loopback shift register
    // driven by the strobes, and scores the transfer when Done appears.
    logic               m_active = 1'b0;
    logic               m_prev_sck;
    int                 m_start, m_rd, m_wr, m_rise, m_bad, m_csn;
    logic [SPI_LEN-1:0] m_sr, m_rx, m_want;

    always @(negedge Clk) begin
        if (!m_active && IsLoad && !Rst) begin
            m_active   = 1'b1;
            m_start    = cyc;
            m_rd       = 0;
            m_wr       = 0;
            m_rise     = 0;
            m_bad      = 0;
            m_csn      = 0;
            m_rx       = '0;
            m_prev_sck = 1'b0;
            m_sr       = (tx_q.size() > 0) ? tx_q.pop_front() : '0;
        end
        if (m_active) begin
            if (!CsN) m_csn++;
            if (Sck && !m_prev_sck) m_rise++;
            if (SckRd && SckWr) m_bad++;
            if (SftEn != (SckRd || SckWr)) m_bad++;
            if (SckRd) begin
                m_rd++;
                if (!(Sck && !m_prev_sck)) m_bad++;
                m_rx = {m_rx[SPI_LEN-2:0], m_sr[SPI_LEN-1]};
            end
            if (SckWr) begin
                m_wr++;
                if (Sck || !m_prev_sck) m_bad++;
                m_sr = m_sr << 1;
            end
            m_prev_sck = Sck;
            if (Done) begin
                m_active = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    m_want = exp_q.pop_front();
                    check("xfer_len", cyc - m_start + 1, XFER_LEN);
                    check("sck_rd_count", m_rd, int'(SPI_LEN));
                    check("sck_wr_count", m_wr, int'(SPI_LEN) - 1);
                    check("sck_rise_count", m_rise, int'(SPI_LEN));
                    check("strobe_rules", m_bad, 0);
                    check("csn_low_cycles", m_csn, XFER_LEN - 1);
                    check("done_csn_sck", int'({CsN, Sck}), 2);
                    check("loopback_rx", int'(m_rx), int'(m_want));
                end
            end else if (!Busy) begin
                m_active = 1'b0;
            end
        end else if (Done) begin
            check("unexpected_done", 1, 0);
        end
    end

    task automatic pulse_start(input logic [SPI_LEN-1:0] tx, input bit completes);
        tx_q.push_back(tx);
        if (completes) exp_q.push_back(tx);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (Busy && n < budget) begin
            @(negedge Clk);
            n++;
        end
        if (Busy) check("idle_timeout", 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rd, wr, tog, rises, quiet, k, gap, f_start;
        logic prev;
        logic [SPI_LEN-1:0] tx;
        bit do_abort;

        Rst = 1'b1; Start = 1'b0; Abort = 1'b0; Start_f = 1'b0; Abort_f = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset_outputs", outs(), 'h80);
        check("reset_outputs_fast", outs_f(), 'h80);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);

        // Single transfer of 0xA5, default timing.
        pulse_start(8'hA5, 1'b1);
        check("load_cycle", int'({IsLoad, CsN, Busy}), 5);
        wait_idle(100);

        // CLK_DIV=1 instance: 20-cycle transfer, Sck toggling every shift cycle.
        Start_f = 1'b1;
        @(negedge Clk);
        Start_f = 1'b0;
        f_start = cyc; rd = 0; wr = 0; tog = 0; prev = Sck_f; n = 0;
        while (!Done_f && n < 100) begin
            if (SckRd_f) rd++;
            if (SckWr_f) wr++;
            if (Sck_f != prev) tog++;
            prev = Sck_f;
            @(negedge Clk);
            n++;
        end
        check("fast_len", cyc - f_start + 1, F_LEN);
        check("fast_rd_count", rd, int'(SPI_LEN));
        check("fast_wr_count", wr, int'(SPI_LEN) - 1);
        check("fast_sck_toggles", tog, 2 * int'(SPI_LEN));
        @(negedge Clk);

        // Start held high: back-to-back transfers with a two-cycle CsN gap.
        tx_q.push_back(8'h3C); exp_q.push_back(8'h3C);
        tx_q.push_back(8'hC3); exp_q.push_back(8'hC3);
        Start = 1'b1;
        n = 0;
        while (!Done && n < 100) begin @(negedge Clk); n++; end
        n = 0;
        while (CsN && n < 10) begin n++; @(negedge Clk); end
        check("b2b_csn_gap", n, 2);
        check("b2b_reload", int'(IsLoad), 1);
        Start = 1'b0;
        wait_idle(100);

        // Abort after the third Sck rise, then a full transfer.
        pulse_start(8'h96, 1'b0);
        rises = 0; prev = 1'b0; n = 0;
        while (rises < 3 && n < 200) begin
            if (Sck && !prev) rises++;
            prev = Sck;
            if (rises < 3) begin @(negedge Clk); n++; end
        end
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        check("abort_outputs", outs(), 'h80);
        quiet = 0;
        repeat (50) begin
            @(negedge Clk);
            if (SckRd || SckWr || SftEn || Done || !CsN || Sck) quiet++;
        end
        check("abort_quiet", quiet, 0);
        pulse_start(8'h5A, 1'b1);
        wait_idle(100);

        // Asynchronous reset mid-shift; afterwards Start+Abort must not launch.
        pulse_start(8'hF0, 1'b0);
        repeat (10) @(negedge Clk);
        #2 Rst = 1'b1;
        #1 check("async_reset", outs(), 'h80);
        @(negedge Clk);
        Rst = 1'b0;
        quiet = 0;
        repeat (4) begin
            @(negedge Clk);
            if (Busy || IsLoad) quiet++;
        end
        check("no_restart_after_reset", quiet, 0);
        Start = 1'b1; Abort = 1'b1;
        quiet = 0;
        repeat (3) begin
            @(negedge Clk);
            if (Busy || IsLoad || !CsN) quiet++;
        end
        check("start_abort_idle", quiet, 0);
        Start = 1'b0; Abort = 1'b0;
        @(negedge Clk);

        // Randomized transfers, some aborted, some with a stray Start while busy.
        for (int i = 0; i < 24; i++) begin
            tx       = SPI_LEN'($urandom);
            do_abort = ($urandom_range(0, 3) == 0);
            gap      = $urandom_range(0, 3);
            repeat (gap) @(negedge Clk);
            pulse_start(tx, !do_abort);
            if (do_abort) begin
                k = $urandom_range(0, XFER_LEN - 3);
                repeat (k) @(negedge Clk);
                Abort = 1'b1;
                @(negedge Clk);
                Abort = 1'b0;
                check("rand_abort_idle", int'({Busy, CsN, Done}), 2);
            end else begin
                k = $urandom_range(1, XFER_LEN - 1);
                repeat (k) @(negedge Clk);
                Start = 1'b1;
                @(negedge Clk);
                Start = 1'b0;
                wait_idle(100);
            end
        end

        repeat (20) @(negedge Clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("tx_queue_empty", tx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
